// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the Z80 timing/interrupt controller.
//   spd_e        turbo select encodings (each step doubles the CPU rate)
//   DIV_W_DEF    default divider width (16 master clocks per T-state)
//   INT_LEN_DEF  default frame interrupt length in T-states
//   cpu_period   T-state length in master clocks for a divider width/speed
package cpu_pkg;

  typedef enum logic [1:0] {
    SPD_X1 = 2'd0,
    SPD_X2 = 2'd1,
    SPD_X4 = 2'd2,
    SPD_X8 = 2'd3
  } spd_e;

  localparam int unsigned DIV_W_DEF   = 4;
  localparam int unsigned INT_LEN_DEF = 32;

  // Caller guarantees spd <= div_w-1, so the period is always >= 2.
  function automatic int unsigned cpu_period(input int unsigned div_w,
                                             input logic [1:0]  spd);
    return 32'd1 << (div_w - 32'(spd));
  endfunction

endpackage

// File: rtl/cpu_int_gen.sv
// cpu_int_gen: frame interrupt generator.
//   clock, reset  master clock, async active-low reset
//   pe            T-state strobe; counts down the pulse length
//   vsync         frame sync; a rising edge starts the pulse while idle
//   m1, iorq      core M1_n / IORQ_n, used only when CPU_INT_ACK_EN is defined
//   irq           INT_n to the core, active low, registered
// Macro CPU_INT_ACK_EN: release irq early on an interrupt acknowledge cycle.
module cpu_int_gen
  import cpu_pkg::*;
#(
  parameter int unsigned INT_LEN = INT_LEN_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic pe,
  input  logic vsync,
  input  logic m1,
  input  logic iorq,
  output logic irq
);

  logic       irq_q, irq_d;
  logic       vsync_dly_q, vsync_dly_d;
  logic [7:0] icnt_q, icnt_d;

  always_comb begin
    irq_d       = irq_q;
    icnt_d      = icnt_q;
    vsync_dly_d = vsync;
    if (irq_q) begin
      // Edges during an active pulse fall in the else branch and are dropped,
      // including one that lands on the releasing tick.
      if (vsync && !vsync_dly_q) begin
        irq_d  = 1'b0;
        icnt_d = 8'(INT_LEN - 1);
      end
    end else if (pe) begin
      if (icnt_q == 8'd0) begin
        irq_d = 1'b1;
      end else begin
        icnt_d = icnt_q - 8'd1;
      end
    end
`ifdef CPU_INT_ACK_EN
    if (!irq_q && !m1 && !iorq) begin
      irq_d  = 1'b1;
      icnt_d = 8'd0;
    end
`endif
  end

`ifndef CPU_INT_ACK_EN
  logic unused_ack;
  assign unused_ack = m1 & iorq;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_q       <= 1'b1;
      icnt_q      <= '0;
      vsync_dly_q <= 1'b0;
    end else begin
      irq_q       <= irq_d;
      icnt_q      <= icnt_d;
      vsync_dly_q <= vsync_dly_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: rtl/cpu_clk_ctl.sv
// cpu_clk_ctl: clock-enable and interrupt controller for the Z80 core wrapper.
//   clock    master clock
//   reset    asynchronous reset, active low
//   speed    turbo select (0 = base, each step doubles), clamped to DIV_W-1
//   contend  hold the CPU at the end of the current T-state
//   vsync    frame sync, active high, synchronous to clock
//   m1, iorq core M1_n / IORQ_n (acknowledge, only with CPU_INT_ACK_EN)
//   pe, ne   one-clock positive/negative edge enables to CEN_p / CEN_n
//   irq      INT_n to the core, active low
//   tick     pe qualified by irq low
// Macro CPU_INT_ACK_EN: enables early irq release on interrupt acknowledge.
module cpu_clk_ctl
  import cpu_pkg::*;
#(
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned INT_LEN = INT_LEN_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] speed,
  input  logic       contend,
  input  logic       vsync,
  input  logic       m1,
  input  logic       iorq,
  output logic       pe,
  output logic       ne,
  output logic       irq,
  output logic       tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] last_cnt, half_cnt;
  spd_e             spd_q, spd_d, spd_clamp;
  logic             pe_q, pe_d;
  logic             ne_q, ne_d;
  int unsigned      per;

  // Speed only changes on a wrap (cnt back to 0), so cnt never exceeds last_cnt.
  always_comb begin
    per       = cpu_period(DIV_W, spd_q);
    last_cnt  = DIV_W'(per - 32'd1);
    half_cnt  = DIV_W'((per >> 1) - 32'd1);
    spd_clamp = (32'(speed) > DIV_W - 1) ? spd_e'(2'(DIV_W - 1)) : spd_e'(speed);
  end

  always_comb begin
    cnt_d = cnt_q;
    spd_d = spd_q;
    pe_d  = 1'b0;
    if (cnt_q == last_cnt) begin
      // Contention holds cnt at the last count; pe waits for contend low.
      if (!contend) begin
        cnt_d = '0;
        pe_d  = 1'b1;
        spd_d = spd_clamp;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    ne_d = (cnt_q == half_cnt);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      spd_q <= SPD_X1;
      pe_q  <= 1'b0;
      ne_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      spd_q <= spd_d;
      pe_q  <= pe_d;
      ne_q  <= ne_d;
    end
  end

  cpu_int_gen #(
    .INT_LEN (INT_LEN)
  ) u_int_gen (
    .clock (clock),
    .reset (reset),
    .pe    (pe_q),
    .vsync (vsync),
    .m1    (m1),
    .iorq  (iorq),
    .irq   (irq)
  );

  assign pe   = pe_q;
  assign ne   = ne_q;
  // Gate of two flop outputs; includes the releasing pe since irq rises a clock later.
  assign tick = pe_q & ~irq;

endmodule

// File: tb/tb_cpu_clk_ctl.sv
module tb_cpu_clk_ctl;
  import cpu_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] speed;
  logic       contend, vsync, m1, iorq;
  logic       pe, ne, irq, tick;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base     = 0;
  int coinc    = 0;
  int irq_low_seen = 0;
  int exp_q[$];

  cpu_clk_ctl #(
    .DIV_W   (4),
    .INT_LEN (32)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .speed   (speed),
    .contend (contend),
    .vsync   (vsync),
    .m1      (m1),
    .iorq    (iorq),
    .pe      (pe),
    .ne      (ne),
    .irq     (irq),
    .tick    (tick)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Wait (bounded) for pe or ne; returns clock index relative to reset release, -1 on timeout.
  task automatic wait_sig(input bit want_ne, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (pe && ne) coinc++;
      if (!irq) irq_low_seen++;
      if (want_ne ? ne : pe) begin
        t = cyc - base;
        break;
      end
    end
  endtask

  // Scoreboard pop: compare the observed event time against the queued expectation.
  task automatic expect_evt(input string tag, input bit want_ne);
    int t;
    int e;
    wait_sig(want_ne, 40, t);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -2;
    check(tag, t, e);
  endtask

  // Start a frame pulse and count ticks until irq returns high.
  task automatic run_pulse(input int ack_at, input int vs2_at,
                           output int ticks, output int rel, output bit done);
    int ack_cyc;
    ticks   = 0;
    rel     = -1;
    done    = 1'b0;
    ack_cyc = -1;
    vsync   = 1'b1;
    @(negedge clock);
    vsync = 1'b0;
    check("irq_asserted", irq, 0);
    for (int i = 0; i < 1200; i++) begin
      @(negedge clock);
      if (!m1) begin
        m1   = 1'b1;
        iorq = 1'b1;
      end
      if (vsync) vsync = 1'b0;
      if (irq) begin
        done = 1'b1;
        if (ack_cyc >= 0) rel = cyc - ack_cyc;
        break;
      end
      if (tick) begin
        ticks++;
        if (ticks == vs2_at) vsync = 1'b1;
        if (ticks == ack_at) begin
          m1      = 1'b0;
          iorq    = 1'b0;
          ack_cyc = cyc;
        end
      end
    end
  endtask

  initial begin
    int  ticks, rel, t;
    bit  done;
    int  pe_seen;

    speed   = SPD_X1;
    contend = 1'b0;
    vsync   = 1'b0;
    m1      = 1'b1;
    iorq    = 1'b1;
    reset   = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_pe", pe, 0);
    check("rst_ne", ne, 0);
    check("rst_irq", irq, 1);
    check("rst_tick", tick, 0);

    // Base rate: ne at 8, pe at 16, then every 16.
    reset = 1'b1;
    base  = cyc;
    coinc = 0;
    exp_q.push_back(8);  expect_evt("ne_first", 1'b1);
    exp_q.push_back(16); expect_evt("pe_first", 1'b0);
    exp_q.push_back(24); expect_evt("ne_second", 1'b1);
    exp_q.push_back(32); expect_evt("pe_second", 1'b0);

    // Turbo x8 applied at cnt=5: T-state ends at 48, then period 2.
    repeat (5) @(negedge clock);
    speed = SPD_X8;
    exp_q.push_back(48); expect_evt("pe_speed_wrap", 1'b0);
    exp_q.push_back(49); expect_evt("ne_turbo", 1'b1);
    exp_q.push_back(50); expect_evt("pe_turbo_a", 1'b0);
    exp_q.push_back(52); expect_evt("pe_turbo_b", 1'b0);
    speed = SPD_X1;
    exp_q.push_back(54); expect_evt("pe_back_wrap", 1'b0);
    exp_q.push_back(70); expect_evt("pe_back_base", 1'b0);

    // Contention for 5 clocks starting at cnt=15.
    repeat (15) @(negedge clock);
    contend = 1'b1;
    pe_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (pe) pe_seen++;
    end
    contend = 1'b0;
    check("pe_stalled", pe_seen, 0);
    exp_q.push_back(91);  expect_evt("pe_after_contend", 1'b0);
    exp_q.push_back(99);  expect_evt("ne_after_contend", 1'b1);
    exp_q.push_back(107); expect_evt("pe_next_period", 1'b0);
    check("no_pe_ne_overlap", coinc, 0);

    // Full-length pulse; second vsync edge at tick 10 is ignored.
    run_pulse(0, 10, ticks, rel, done);
    check("irq_released", done, 1);
    check("irq_len", ticks, 32);

    // Acknowledge at tick 3.
    run_pulse(3, 0, ticks, rel, done);
    check("ack_released", done, 1);
`ifdef CPU_INT_ACK_EN
    check("ack_ticks", ticks, 3);
    check("ack_latency", rel, 1);
`else
    check("noack_ticks", ticks, 32);
`endif

    // Reset mid-pulse at cnt=9.
    vsync = 1'b1;
    @(negedge clock);
    vsync = 1'b0;
    wait_sig(1'b0, 40, t);
    repeat (9) @(negedge clock);
    check("irq_low_before_reset", irq, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_pe", pe, 0);
    check("mid_rst_ne", ne, 0);
    check("mid_rst_irq", irq, 1);
    repeat (2) @(negedge clock);
    reset        = 1'b1;
    base         = cyc;
    irq_low_seen = 0;
    exp_q.push_back(16); expect_evt("pe_after_reset", 1'b0);
    check("no_stale_irq", irq_low_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
